// File: rtl/rect_draw_sequencer.sv
// ============================================================================
// Module   : rect_draw_sequencer
// Purpose  : Buffers rectangle-fill commands and rasters each one, one pixel
//            per clock, onto the VGA adapter pixel-write port.
// Options  : RECT_CLIP_EN - suppress plot for pixels outside SCREEN_W x SCREEN_H
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rect_draw_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x0,
  input  logic [6:0] cmd_y0,
  input  logic [7:0] cmd_w,
  input  logic [6:0] cmd_h,
  input  logic [2:0] cmd_colour,
  input  logic       flush,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done,
  output logic       busy
);

  localparam int                 c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [32:0]        r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic [7:0] r_x0, r_w, r_cx;
  logic [6:0] r_y0, r_h, r_cy;
  logic [2:0] r_col;

  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_done;

  logic       w_push, w_pop;
  logic       w_last_col, w_last_row;
  logic [7:0] w_ncx, w_pcx;
  logic [6:0] w_ncy, w_pcy;
  logic [7:0] w_px;
  logic [6:0] w_py;
  logic       w_pix_on;

  // Illegal parameter combinations leave this block behind as a marker.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SCREEN_W < 1 || SCREEN_W > 256 || SCREEN_H < 1 || SCREEN_H > 128) begin : g_bad_params
  end

  assign cmd_ready = (r_count != c_depth);
  assign w_push    = cmd_valid && cmd_ready && !flush;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && !flush;
  assign busy      = (r_count != '0) || (r_state != S_IDLE);

  assign w_last_col = (r_cx == r_w - 8'd1);
  assign w_last_row = (r_cy == r_h - 7'd1);
  assign w_ncx      = w_last_col ? 8'd0 : r_cx + 8'd1;
  assign w_ncy      = w_last_col ? r_cy + 7'd1 : r_cy;

  // The pixel presented after the coming edge: origin when leaving LOAD.
  assign w_pcx = (r_state == S_LOAD) ? 8'd0 : w_ncx;
  assign w_pcy = (r_state == S_LOAD) ? 7'd0 : w_ncy;

`ifdef RECT_CLIP_EN
  logic [8:0] w_px_wide;
  logic [7:0] w_py_wide;

  assign w_px_wide = {1'b0, r_x0} + {1'b0, w_pcx};
  assign w_py_wide = {1'b0, r_y0} + {1'b0, w_pcy};
  assign w_px      = w_px_wide[7:0];
  assign w_py      = w_py_wide[6:0];
  assign w_pix_on  = (w_px_wide < 9'(SCREEN_W)) && (w_py_wide < 8'(SCREEN_H));
`else
  assign w_px      = r_x0 + w_pcx;
  assign w_py      = r_y0 + w_pcy;
  assign w_pix_on  = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_col    <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else if (flush) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      r_done <= 1'b0;

      if (w_push) begin
        r_mem[r_wr_ptr] <= {cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_colour};
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_x0, r_y0, r_w, r_h, r_col} <= r_mem[r_rd_ptr];
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cx <= 8'd0;
          r_cy <= 7'd0;
          if (r_w == 8'd0 || r_h == 7'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_DRAW;
            r_plot  <= w_pix_on;
            if (w_pix_on) begin
              r_x      <= w_px;
              r_y      <= w_py;
              r_colour <= r_col;
            end
          end
        end
        S_DRAW: begin
          if (w_last_col && w_last_row) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cx   <= w_ncx;
            r_cy   <= w_ncy;
            r_plot <= w_pix_on;
            if (w_pix_on) begin
              r_x      <= w_px;
              r_y      <= w_py;
              r_colour <= r_col;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rect_draw_sequencer.sv
// ============================================================================
// Module   : tb_rect_draw_sequencer
// Purpose  : Randomised self-checking bench for rect_draw_sequencer against a
//            pixel-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rect_draw_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x0;
  logic [6:0] cmd_y0;
  logic [7:0] cmd_w;
  logic [6:0] cmd_h;
  logic [2:0] cmd_colour;
  logic       flush;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  // Expected output events in order: {is_done, x, y, colour}.
  logic [18:0] exp_q [$];
  localparam logic [18:0] c_done_ev = {1'b1, 18'd0};
  localparam logic [18:0] c_none_ev = 19'h7FFFF;

  rect_draw_sequencer #(.FIFO_DEPTH(4), .SCREEN_W(160), .SCREEN_H(120)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_colour (cmd_colour),
    .flush      (flush),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .done       (done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Every pixel of the rectangle in raster order, then its completion.
  function automatic void add_cmd(input int x0, input int y0, input int w, input int h, input int c);
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        int px = x0 + i;
        int py = y0 + j;
`ifdef RECT_CLIP_EN
        if (px >= 160 || py >= 120) continue;
`endif
        exp_q.push_back({1'b0, 8'(px % 256), 7'(py % 128), 3'(c)});
      end
    end
    exp_q.push_back(c_done_ev);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      if (flush) exp_q.delete();
      else if (cmd_valid && cmd_ready)
        add_cmd(int'(cmd_x0), int'(cmd_y0), int'(cmd_w), int'(cmd_h), int'(cmd_colour));
    end
  end

  always @(negedge clock) begin
    logic [18:0] ev;
    if (reset) begin
      if (plot) begin
        ev = (exp_q.size() != 0) ? exp_q.pop_front() : c_none_ev;
        check_eq("pixel", 32'({1'b0, x, y, colour}), 32'(ev));
      end
      if (done) begin
        n_done++;
        ev = (exp_q.size() != 0) ? exp_q.pop_front() : c_none_ev;
        check_eq("done_order", 32'(c_done_ev), 32'(ev));
      end
    end
  end

  // Entered and left at a falling edge; cmd_valid stays high when keep is set.
  task automatic push_cmd(input int x0, input int y0, input int w, input int h, input int c,
                          input bit keep, output int waited);
    cmd_x0 = 8'(x0); cmd_y0 = 7'(y0); cmd_w = 8'(w); cmd_h = 7'(h); cmd_colour = 3'(c);
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20000) begin
      @(negedge clock);
      waited++;
    end
    if (!cmd_ready) check_eq("push_accept", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic measure(output int k, output int np, output int first_k, output int last_k,
                         output int fx, output int fy, output int lx, output int ly);
    k = 0; np = 0; first_k = -1; last_k = -1; fx = 0; fy = 0; lx = 0; ly = 0;
    do begin
      @(negedge clock);
      k++;
      if (plot) begin
        np++;
        if (first_k < 0) begin first_k = k; fx = int'(x); fy = int'(y); end
        last_k = k; lx = int'(x); ly = int'(y);
      end
    end while (!done && k < 20000);
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 20000) begin
      @(negedge clock);
      g++;
    end
    check_eq("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    int wt, k, np, fk, lk, fx, fy, lx, ly, d0, g;
    reset = 1'b0; cmd_valid = 1'b0; flush = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0;

    #3;
    check_eq("rst_plot",   32'(plot),      32'd0);
    check_eq("rst_done",   32'(done),      32'd0);
    check_eq("rst_busy",   32'(busy),      32'd0);
    check_eq("rst_ready",  32'(cmd_ready), 32'd1);
    check_eq("rst_xy",     32'({x, y}),    32'd0);
    check_eq("rst_colour", 32'(colour),    32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Full-height strip: latency, pixel count, done and busy timing.
    push_cmd(30, 0, 100, 120, 0, 1'b0, wt);
    measure(k, np, fk, lk, fx, fy, lx, ly);
    check_eq("strip_plots",   32'(np), 32'd12000);
    check_eq("strip_first_k", 32'(fk), 32'd2);
    check_eq("strip_first_xy", 32'({fx[7:0], fy[6:0]}), 32'({8'd30, 7'd0}));
    check_eq("strip_last_xy",  32'({lx[7:0], ly[6:0]}), 32'({8'd129, 7'd119}));
    check_eq("strip_done_k",  32'(k),  32'd12002);
    check_eq("strip_lastplot_k", 32'(lk), 32'(k - 1));
    @(negedge clock);
    check_eq("strip_busy_after", 32'(busy), 32'd0);

    // Empty rectangles complete in LOAD + DONE.
    push_cmd(10, 10, 0, 5, 3, 1'b0, wt);
    measure(k, np, fk, lk, fx, fy, lx, ly);
    check_eq("empty_w_plots", 32'(np), 32'd0);
    check_eq("empty_w_done_k", 32'(k), 32'd2);
    push_cmd(10, 10, 5, 0, 3, 1'b0, wt);
    measure(k, np, fk, lk, fx, fy, lx, ly);
    check_eq("empty_h_done_k", 32'(k), 32'd2);
    @(negedge clock);

    // Fill the FIFO behind a drawing rectangle; the sixth must wait.
    d0 = n_done;
    for (int i = 0; i < 5; i++) begin
      push_cmd(i * 20, 40, 4, 12, i + 1, 1'b1, wt);
      check_eq("fill_no_wait", 32'(wt), 32'd0);
    end
    check_eq("full_ready", 32'(cmd_ready), 32'd0);
    check_eq("full_busy",  32'(busy),      32'd1);
    push_cmd(100, 100, 4, 12, 7, 1'b0, wt);
    check_eq("sixth_waited", 32'(wt > 0), 32'd1);
    wait_idle();
    check_eq("fill_done_count", 32'(n_done - d0), 32'd6);
    check_eq("fill_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush at the tenth pixel with two commands queued, plus a same-cycle push.
    push_cmd(20, 20, 4, 12, 5, 1'b1, wt);
    push_cmd(60, 20, 4, 12, 6, 1'b1, wt);
    push_cmd(90, 20, 4, 12, 2, 1'b0, wt);
    np = 0; g = 0;
    while (g < 1000) begin
      if (plot) np++;
      if (np == 10) break;
      @(negedge clock);
      g++;
    end
    check_eq("flush_at_pixel", 32'(np), 32'd10);
    d0 = n_done;
    flush = 1'b1;
    cmd_x0 = 8'd1; cmd_y0 = 7'd1; cmd_w = 8'd2; cmd_h = 7'd2; cmd_colour = 3'd1; cmd_valid = 1'b1;
    @(negedge clock);
    flush = 1'b0; cmd_valid = 1'b0;
    check_eq("flush_plot",  32'(plot),      32'd0);
    check_eq("flush_busy",  32'(busy),      32'd0);
    check_eq("flush_ready", 32'(cmd_ready), 32'd1);
    repeat (5) @(negedge clock);
    check_eq("flush_stay_idle", 32'(busy), 32'd0);
    check_eq("flush_no_done", 32'(n_done - d0), 32'd0);

    // Edge-of-screen box: all 16 pixels without clipping, 4 with it.
    push_cmd(158, 118, 4, 4, 6, 1'b0, wt);
    measure(k, np, fk, lk, fx, fy, lx, ly);
`ifdef RECT_CLIP_EN
    check_eq("edge_plots", 32'(np), 32'd4);
`else
    check_eq("edge_plots", 32'(np), 32'd16);
`endif
    check_eq("edge_done_k", 32'(k), 32'd18);
    @(negedge clock);

    // Random commands with wrap-around, gaps and occasional flushes.
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      if ($urandom_range(0, 11) == 0) begin
        flush = 1'b1;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_w = 8'($urandom_range(1, 4)); cmd_h = 7'($urandom_range(1, 4));
        @(negedge clock);
        flush = 1'b0; cmd_valid = 1'b0;
      end else begin
        push_cmd($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 12),
                 $urandom_range(0, 6), $urandom_range(0, 7), 1'b0, wt);
      end
    end
    wait_idle();
    check_eq("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a rectangle.
    push_cmd(5, 5, 8, 8, 2, 1'b0, wt);
    g = 0;
    while (!plot && g < 100) begin
      @(negedge clock);
      g++;
    end
    check_eq("areset_drawing", 32'(plot), 32'd1);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    check_eq("areset_plot",  32'(plot), 32'd0);
    check_eq("areset_done",  32'(done), 32'd0);
    check_eq("areset_busy",  32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("areset_idle_busy",  32'(busy),      32'd0);
    check_eq("areset_idle_ready", 32'(cmd_ready), 32'd1);
    check_eq("areset_idle_plot",  32'(plot),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
